// File: rtl/zymason_scan_sched.sv
// zymason_scan_sched: time-multiplexed digit scan sequencer and store write arbiter.
// Ports: clock/reset (async, active-high); tick_div/on_cycles/skip_mask configure
// the scan; wr_req/wr_idx -> wr_ack request a store write; dig_sel/store_we/drive_en
// drive the digit stores and segment bus; slot_idx/frame_done report scan progress.
module zymason_scan_sched #(
    parameter int NUM_DIGITS = 8,
    parameter int CNT_W      = 9,
    localparam int IW        = $clog2(NUM_DIGITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CNT_W-1:0]      tick_div,
    input  logic [CNT_W-1:0]      on_cycles,
    input  logic [NUM_DIGITS-1:0] skip_mask,
    input  logic                  wr_req,
    input  logic [IW-1:0]         wr_idx,
    output logic                  wr_ack,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  store_we,
    output logic                  drive_en,
    output logic [IW-1:0]         slot_idx,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_GAP
    } state_t;

    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    state_t          state_q, state_d;
    logic            active_q, active_d;
    logic [IW-1:0]   idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_DIGITS-1:0] dig_d;
    logic            drive_d, we_d, ack_d, fd_d;

    logic            any_free;
    logic [IW-1:0]   low_idx;
    logic [IW-1:0]   nxt_idx;
    logic            nxt_found;
    logic [IW-1:0]   cand;
    logic            wr_ok;

    logic            st_active;
    logic [IW-1:0]   st_idx;
    logic [CNT_W-1:0] st_cnt;
    logic            st_fd;

    assign any_free = ~&skip_mask;
    assign wr_ok    = (int'(wr_idx) < NUM_DIGITS);

    // Lowest unmasked index: descending scan so the smallest hit is kept.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!skip_mask[i]) low_idx = IW'(i);
        end
    end

    // Next unmasked index after slot_idx with wrap; offset NUM_DIGITS
    // revisits the current digit so a lone digit keeps scanning.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        cand      = '0;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            cand = IW'((int'(slot_idx) + k) % NUM_DIGITS);
            if (!skip_mask[cand]) begin
                nxt_found = 1'b1;
                nxt_idx   = cand;
            end
        end
    end

    // One scan step from the held position. A write defers this step,
    // which both freezes the slot and postpones a pending boundary.
    always_comb begin
        st_active = active_q;
        st_idx    = slot_idx;
        st_cnt    = cnt_q;
        st_fd     = 1'b0;
        if (!active_q) begin
            if (any_free) begin
                st_active = 1'b1;
                st_idx    = low_idx;
                st_cnt    = '0;
            end
        end else if (cnt_q >= tick_div) begin
            st_cnt = '0;
            if (nxt_found) begin
                st_idx = nxt_idx;
                st_fd  = (nxt_idx <= slot_idx);
            end else begin
                st_active = 1'b0;
            end
        end else begin
            st_cnt = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        idx_d    = slot_idx;
        cnt_d    = cnt_q;
        dig_d    = '0;
        drive_d  = 1'b0;
        we_d     = 1'b0;
        ack_d    = 1'b0;
        fd_d     = 1'b0;
        unique case (state_q)
            S_IDLE, S_SCAN: begin
                if (wr_req) begin
                    state_d = S_WRITE;
                    ack_d   = 1'b1;
                    if (wr_ok) begin
                        we_d  = 1'b1;
                        dig_d = ONE << wr_idx;
                    end
                end else begin
                    state_d = st_active ? S_SCAN : S_IDLE;
                end
            end
            S_WRITE: state_d = S_GAP;
            S_GAP:   state_d = st_active ? S_SCAN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Every non-write cycle advances the scan.
        if (state_d != S_WRITE) begin
            active_d = st_active;
            idx_d    = st_idx;
            cnt_d    = st_cnt;
            fd_d     = st_fd;
            dig_d    = st_active ? (ONE << st_idx) : '0;
            drive_d  = st_active && (st_cnt < on_cycles);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            active_q   <= 1'b0;
            slot_idx   <= '0;
            cnt_q      <= '0;
            dig_sel    <= '0;
            drive_en   <= 1'b0;
            store_we   <= 1'b0;
            wr_ack     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            slot_idx   <= idx_d;
            cnt_q      <= cnt_d;
            dig_sel    <= dig_d;
            drive_en   <= drive_d;
            store_we   <= we_d;
            wr_ack     <= ack_d;
            frame_done <= fd_d;
        end
    end

endmodule

// File: doc/zymason_scan_sched.md
# zymason_scan_sched

Scan scheduler and write arbiter for the 8-digit seven-segment store. Sequences time-multiplexed display of the stored digits over the shared segment bus with a programmable slot length, per-digit skip mask and on-time (brightness) control. Arbitrates the single store-enable path between the display scanner and a write requester. Sits between the mode FSM and pin decode on one side, and the one-hot digit-enable lines of the digit stores and segment drivers on the other.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digit slots; index width IW = $clog2(NUM_DIGITS)
- CNT_W, 9, width of slot counter, tick_div and on_cycles

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- tick_div  in  CNT_W  scan-slot length minus 1, in clocks
- on_cycles  in  CNT_W  clocks per slot with segments driven; 0 = blank, >= tick_div+1 = full on
- skip_mask  in  NUM_DIGITS  bit i = 1 excludes digit i from scan
- wr_req  in  1  write request, level; held until wr_ack
- wr_idx  in  IW  digit index to write
- wr_ack  out  1  one-cycle grant; the write occurs in this cycle
- dig_sel  out  NUM_DIGITS  one-hot digit enable to stores/drivers, or 0
- store_we  out  1  store write strobe, coincident with wr_ack
- drive_en  out  1  segment bus drive enable
- slot_idx  out  IW  current scan index
- frame_done  out  1  one-cycle pulse on scan wrap

## Operation
- All outputs registered. Reset values: state IDLE, slot_idx 0, slot_cnt 0, dig_sel 0, drive_en 0, store_we 0, wr_ack 0, frame_done 0.
- States: IDLE (no eligible digit), SCAN, WRITE, GAP (one-cycle post-write return).
- IDLE: dig_sel 0, drive_en 0. When skip_mask has any 0 bit, go to SCAN with slot_idx = lowest unmasked index, slot_cnt 0.
- SCAN: dig_sel = onehot(slot_idx); drive_en = (slot_cnt < on_cycles); slot_cnt increments each cycle.
- Slot boundary, when slot_cnt == tick_div: slot_cnt -> 0; slot_idx -> next unmasked index, searching ascending from slot_idx+1 with wrap. Skip_mask is sampled only at boundaries; a mid-slot change does not shorten the current slot.
- frame_done pulses in the first cycle of the new slot when the new index <= old index. This includes the single-eligible-digit case, where the pulse occurs every slot.
- All digits masked at a boundary: go to IDLE; frame_done 0.
- Write: wr_req sampled in SCAN or IDLE -> WRITE for exactly one cycle with dig_sel = onehot(wr_idx), store_we 1, wr_ack 1, drive_en 0. Slot_cnt and slot_idx are frozen.
- wr_idx >= NUM_DIGITS: wr_ack 1, store_we 0, dig_sel 0 (request consumed, no write).
- After WRITE, always GAP for one cycle, then return to the prior state: SCAN with frozen slot_cnt/slot_idx, or IDLE.
  - GAP behaves as that prior state (dig_sel/drive_en as in SCAN or IDLE), with counting active, but wr_req is ignored.
  - The gap guarantees at least one scan cycle between writes (fairness).
- A request arriving on a slot-boundary cycle wins: the boundary is deferred until the scan resumes.
- Requester must deassert wr_req in the cycle after wr_ack; if still high then, it is a new request granted after GAP.

## Timing
- wr_req high at edge t (state SCAN/IDLE) -> wr_ack/store_we/dig_sel(write) valid after edge t, i.e. during cycle t+1. Minimum 3 cycles between grants.
- Slot length = tick_div+1 non-WRITE cycles; WRITE cycles stretch the slot by one each. tick_div 0: index advances every scan cycle.
- Frame period with k unmasked digits and no writes = k*(tick_div+1) cycles.
- drive_en falls on the cycle slot_cnt reaches on_cycles; dig_sel and drive_en never select a different digit in the same cycle that drive_en is 1 across a change (drive_en is 0 on WRITE cycles).
- Reset asserted mid-WRITE or mid-slot: all outputs to reset values immediately (asynchronous). First scan slot starts on the first edge after release.

## Test plan
- Reset, skip_mask 0, tick_div 3, on_cycles 4 -> dig_sel 01,02,04,..,80, 4 cycles each, drive_en constant 1; frame_done one cycle when dig_sel returns to 01, every 32 cycles.
- skip_mask 8'b1111_0101, tick_div 1, on_cycles 1 -> scan order 1,3,1,3 (2 cycles each, drive_en 1 then 0); frame_done each time index 1 restarts.
- Mid-slot write: slot_idx 2, slot_cnt 1, wr_req with wr_idx 6 -> next cycle dig_sel 8'h40, store_we 1, wr_ack 1, drive_en 0; then slot 2 resumes at slot_cnt 1 and completes full length.
- wr_req held 6 cycles -> wr_ack on cycles 1 and 4 only (GAP enforced); wr_idx 7 -> dig_sel 8'h80 at both grants.
- skip_mask 8'hFF -> IDLE, dig_sel 0, drive_en 0; write wr_idx 0 still acked with dig_sel 01; clear mask bit 5 -> scan only digit 5, frame_done every slot.
- Assert reset during WRITE cycle -> wr_ack, store_we, dig_sel drop to 0 same cycle; after release, scan restarts at digit 0, slot_cnt 0.
